// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a byte-granular word stream into padded 512-bit blocks
// emitted as 16 back-to-back words. Optional macro SHA256_PADDER_BSWAP_EN selects little-endian input bytes.
module sha256_msg_padder #(
    parameter int unsigned LEN_W = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_data_i,
    input  logic        in_last_i,
    input  logic [2:0]  in_bytes_i,
    input  logic        blk_ready_i,
    output logic        ld_o,
    output logic [31:0] M_o,
    output logic        blk_first_o,
    output logic        blk_last_o,
    output logic        busy_o
);

    localparam int unsigned WORDS = 16;

    typedef enum logic [2:0] {S_FILL, S_PAD, S_LEN, S_WAIT, S_EMIT} state_t;

    state_t             state;
    logic [4:0]         wcnt;
    logic [3:0]         ecnt;
    logic [LEN_W-1:0]   bitcnt;
    logic               pend80;
    logic               final_blk;
    logic               padding;
    logic               first;
    logic [31:0]        blk_buf [WORDS];

    logic [31:0]        din_c;
    logic [31:0]        mask_c;
    logic [31:0]        marker_c;
    logic               short_c;
    logic               acc_c;
    logic [4:0]         wcnt_inc_c;
    logic [63:0]        len64_c;
    logic               wr_en_c;
    logic [31:0]        wr_data_c;

`ifdef SHA256_PADDER_BSWAP_EN
    assign din_c = {in_data_i[7:0], in_data_i[15:8], in_data_i[23:16], in_data_i[31:24]};
`else
    assign din_c = in_data_i;
`endif

    assign short_c    = (in_bytes_i < 3'd4);
    assign acc_c      = in_valid_i & in_ready_o;
    assign wcnt_inc_c = wcnt + 5'd1;
    assign len64_c    = 64'(bitcnt);

    // Keep the leading n bytes of a short tail word and place the 0x80 marker right after them.
    always_comb begin
        mask_c   = 32'h0000_0000;
        marker_c = 32'h8000_0000;
        case (in_bytes_i[1:0])
            2'd1:    begin mask_c = 32'hFF00_0000; marker_c = 32'h0080_0000; end
            2'd2:    begin mask_c = 32'hFFFF_0000; marker_c = 32'h0000_8000; end
            2'd3:    begin mask_c = 32'hFFFF_FF00; marker_c = 32'h0000_0080; end
            default: begin mask_c = 32'h0000_0000; marker_c = 32'h8000_0000; end
        endcase
    end

    // Single buffer write port, always addressed by the fill index.
    always_comb begin
        wr_en_c   = 1'b0;
        wr_data_c = 32'h0;
        case (state)
            S_FILL: begin
                if (acc_c) begin
                    wr_en_c   = 1'b1;
                    wr_data_c = (in_last_i && short_c) ? ((din_c & mask_c) | marker_c) : din_c;
                end
            end
            S_PAD: begin
                if (pend80 || (wcnt != 5'd14)) begin
                    wr_en_c   = 1'b1;
                    wr_data_c = pend80 ? 32'h8000_0000 : 32'h0;
                end
            end
            S_LEN: begin
                wr_en_c   = 1'b1;
                wr_data_c = wcnt[0] ? len64_c[31:0] : len64_c[63:32];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) blk_buf[wcnt[3:0]] <= wr_data_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FILL;
            wcnt        <= 5'd0;
            ecnt        <= 4'd0;
            bitcnt      <= '0;
            pend80      <= 1'b0;
            final_blk   <= 1'b0;
            padding     <= 1'b0;
            first       <= 1'b1;
            in_ready_o  <= 1'b1;
            ld_o        <= 1'b0;
            M_o         <= 32'h0;
            blk_first_o <= 1'b0;
            blk_last_o  <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                S_FILL: begin
                    if (acc_c) begin
                        wcnt   <= wcnt_inc_c;
                        busy_o <= 1'b1;
                        if (in_last_i && short_c) begin
                            bitcnt     <= bitcnt + LEN_W'({in_bytes_i, 3'b000});
                            padding    <= 1'b1;
                            in_ready_o <= 1'b0;
                            if (wcnt == 5'd15)      state <= S_WAIT;
                            else if (wcnt == 5'd13) state <= S_LEN;
                            else                    state <= S_PAD;
                        end else begin
                            bitcnt <= bitcnt + LEN_W'(32);
                            if (in_last_i) begin
                                pend80  <= 1'b1;
                                padding <= 1'b1;
                            end
                            if (wcnt == 5'd15) begin
                                state      <= S_WAIT;
                                in_ready_o <= 1'b0;
                            end else if (in_last_i) begin
                                state      <= S_PAD;
                                in_ready_o <= 1'b0;
                            end
                        end
                    end
                end
                S_PAD: begin
                    if (!pend80 && (wcnt == 5'd14)) begin
                        state <= S_LEN;
                    end else begin
                        pend80 <= 1'b0;
                        wcnt   <= wcnt_inc_c;
                        if (wcnt_inc_c == 5'd16)      state <= S_WAIT;
                        else if (wcnt_inc_c == 5'd14) state <= S_LEN;
                    end
                end
                S_LEN: begin
                    wcnt <= wcnt_inc_c;
                    if (wcnt == 5'd15) begin
                        final_blk <= 1'b1;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (blk_ready_i) begin
                        state       <= S_EMIT;
                        ecnt        <= 4'd0;
                        ld_o        <= 1'b1;
                        M_o         <= blk_buf[0];
                        blk_first_o <= first;
                        blk_last_o  <= 1'b0;
                    end
                end
                S_EMIT: begin
                    if (ecnt == 4'd15) begin
                        ld_o        <= 1'b0;
                        M_o         <= 32'h0;
                        blk_first_o <= 1'b0;
                        blk_last_o  <= 1'b0;
                        wcnt        <= 5'd0;
                        ecnt        <= 4'd0;
                        first       <= final_blk;
                        if (final_blk) begin
                            state      <= S_FILL;
                            in_ready_o <= 1'b1;
                            bitcnt     <= '0;
                            final_blk  <= 1'b0;
                            padding    <= 1'b0;
                            busy_o     <= 1'b0;
                        end else if (padding) begin
                            state <= S_PAD;
                        end else begin
                            state      <= S_FILL;
                            in_ready_o <= 1'b1;
                        end
                    end else begin
                        ecnt        <= ecnt + 4'd1;
                        M_o         <= blk_buf[ecnt + 4'd1];
                        blk_first_o <= 1'b0;
                        blk_last_o  <= final_blk && (ecnt == 4'd14);
                    end
                end
                default: begin
                    state      <= S_FILL;
                    in_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed self-checking bench for sha256_msg_padder: short, empty, 56/64-byte messages,
// backpressure in WAIT and reset in the middle of a block.
module tb_sha256_msg_padder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_data_i;
    logic        in_last_i;
    logic [2:0]  in_bytes_i;
    logic        blk_ready_i;
    logic        ld_o;
    logic [31:0] M_o;
    logic        blk_first_o;
    logic        blk_last_o;
    logic        busy_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [33:0] cap[$];
    logic [33:0] exp_q[$];
    int          run_len  = 0;
    int          bad_runs = 0;
    int          idle_nz  = 0;

    sha256_msg_padder #(.LEN_W(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .in_bytes_i  (in_bytes_i),
        .blk_ready_i (blk_ready_i),
        .ld_o        (ld_o),
        .M_o         (M_o),
        .blk_first_o (blk_first_o),
        .blk_last_o  (blk_last_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    // Capture emitted words with their flags; track burst length and idle-bus cleanliness.
    always @(negedge clk) begin
        if (!rst_n) begin
            run_len <= 0;
        end else if (ld_o) begin
            cap.push_back({blk_first_o, blk_last_o, M_o});
            run_len <= run_len + 1;
        end else begin
            if (M_o != 32'h0) idle_nz <= idle_nz + 1;
            if (run_len != 0) begin
                if (run_len != 16) bad_runs <= bad_runs + 1;
                run_len <= 0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] n);
        int t = 0;
        @(negedge clk);
        while (!in_ready_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready_o) check_eq("send_timeout", 64'(in_ready_o), 64'd1);
        in_valid_i = 1'b1;
`ifdef SHA256_PADDER_BSWAP_EN
        in_data_i  = {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        in_data_i  = d;
`endif
        in_last_i  = last;
        in_bytes_i = n;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        in_bytes_i = 3'd4;
    endtask

    task automatic push_exp(input logic f, input logic l, input logic [31:0] d);
        exp_q.push_back({f, l, d});
    endtask

    task automatic push_zeros(input int k);
        for (int i = 0; i < k; i++) exp_q.push_back(34'h0);
    endtask

    task automatic compare(input string tag);
        int t = 0;
        while (cap.size() < exp_q.size() && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_eq($sformatf("%s_count", tag), 64'(cap.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < cap.size()) check_eq($sformatf("%s_w%0d", tag, i), 64'(cap[i]), 64'(exp_q[i]));
        end
        cap.delete();
        exp_q.delete();
    endtask

    task automatic check_idle(input string tag);
        repeat (2) @(negedge clk);
        check_eq({tag, "_busy"}, 64'(busy_o), 64'd0);
        check_eq({tag, "_ready"}, 64'(in_ready_o), 64'd1);
    endtask

    initial begin
        int t;
        rst_n       = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = 32'h0;
        in_last_i   = 1'b0;
        in_bytes_i  = 3'd4;
        blk_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 64'(in_ready_o), 64'd1);
        check_eq("rst_ld", 64'(ld_o), 64'd0);
        check_eq("rst_m", 64'(M_o), 64'd0);
        check_eq("rst_first", 64'(blk_first_o), 64'd0);
        check_eq("rst_last", 64'(blk_last_o), 64'd0);
        check_eq("rst_busy", 64'(busy_o), 64'd0);
        #1 rst_n = 1'b1;

        // "abc"
        send_word(32'h6162_6300, 1'b1, 3'd3);
        push_exp(1'b1, 1'b0, 32'h6162_6380);
        push_zeros(14);
        push_exp(1'b0, 1'b1, 32'h0000_0018);
        compare("abc");
        check_idle("abc");

        // Empty message; garbage data bytes must be masked away
        send_word(32'hFFFF_FFFF, 1'b1, 3'd0);
        push_exp(1'b1, 1'b0, 32'h8000_0000);
        push_zeros(14);
        push_exp(1'b0, 1'b1, 32'h0000_0000);
        compare("empty");
        check_idle("empty");

        // 56 bytes: length spills into a second block
        for (int i = 0; i < 14; i++) begin
            send_word(32'hA000_0000 + 32'(i), i == 13, 3'd4);
            if (i == 0) check_eq("m56_busy_on", 64'(busy_o), 64'd1);
        end
        for (int i = 0; i < 14; i++) push_exp(i == 0, 1'b0, 32'hA000_0000 + 32'(i));
        push_exp(1'b0, 1'b0, 32'h8000_0000);
        push_zeros(16);
        push_exp(1'b0, 1'b1, 32'h0000_01C0);
        compare("m56");
        check_idle("m56");

        // 64 bytes: full data block then a pure padding block
        for (int i = 0; i < 16; i++) send_word(32'hB000_0000 + 32'(i), i == 15, 3'd4);
        check_eq("m64_busy_mid", 64'(busy_o), 64'd1);
        for (int i = 0; i < 16; i++) push_exp(i == 0, 1'b0, 32'hB000_0000 + 32'(i));
        push_exp(1'b0, 1'b0, 32'h8000_0000);
        push_zeros(14);
        push_exp(1'b0, 1'b1, 32'h0000_0200);
        compare("m64");
        check_idle("m64");

        // Backpressure in WAIT, ready dropped mid-block
        blk_ready_i = 1'b0;
        send_word(32'h4142_0000, 1'b1, 3'd2);
        repeat (20) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq($sformatf("bp_ld_%0d", i), 64'(ld_o), 64'd0);
            check_eq($sformatf("bp_ready_%0d", i), 64'(in_ready_o), 64'd0);
        end
        blk_ready_i = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp_rise", 64'(ld_o), 64'd1);
        repeat (3) @(negedge clk);
        blk_ready_i = 1'b0;
        push_exp(1'b1, 1'b0, 32'h4142_8000);
        push_zeros(14);
        push_exp(1'b0, 1'b1, 32'h0000_0010);
        compare("bp");
        blk_ready_i = 1'b1;
        check_idle("bp");

        // Reset during word 7 of a block
        send_word(32'hC0C1_C2C3, 1'b0, 3'd4);
        send_word(32'hD0D1_D2D3, 1'b1, 3'd4);
        t = 0;
        @(negedge clk);
        while (!ld_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_eq("rmid_start", 64'(ld_o), 64'd1);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rmid_ld", 64'(ld_o), 64'd0);
        check_eq("rmid_m", 64'(M_o), 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        cap.delete();
        check_eq("rmid_ready", 64'(in_ready_o), 64'd1);
        check_eq("rmid_busy", 64'(busy_o), 64'd0);
        send_word(32'h6162_6300, 1'b1, 3'd3);
        push_exp(1'b1, 1'b0, 32'h6162_6380);
        push_zeros(14);
        push_exp(1'b0, 1'b1, 32'h0000_0018);
        compare("post_rst");
        check_idle("post_rst");

        check_eq("burst_len", 64'(bad_runs), 64'd0);
        check_eq("idle_bus", 64'(idle_nz), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
